imem_boot_loader: RTL and testbench

- Boot loader: the writer for the instruction memory that the single-cycle CPU only reads.
- Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them to instruction memory at CPU PC addresses.
- Holds the CPU in reset while loading; releases it only after the checksum verifies.
- Sits between the host byte source (UART receiver or test harness) and the Instruction_Memory write port.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/boot_byte_assembler.sv | 69 ++++++
 rtl/imem_boot_loader.sv | 210 +++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-memory boot loader:
// FSM state encoding, error codes and the frame byte order.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } boot_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  // Words travel high byte first on the wire.
  localparam logic FRAME_HI_FIRST = 1'b1;

  function automatic logic [15:0] pack_word(input logic [7:0] first_b,
                                            input logic [7:0] second_b);
    logic [15:0] w;
    if (FRAME_HI_FIRST) begin
      w = {first_b, second_b};
    end else begin
      w = {second_b, first_b};
    end
    return w;
  endfunction

endpackage

// File: rtl/boot_byte_assembler.sv
// Pairs stream bytes into 16-bit words, keeps the running XOR checksum of the
// frame and raises word_valid for one cycle after each completed word.
module boot_byte_assembler
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        take_first,
  input  logic        take_second,
  input  logic        xor_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [15:0] word,
  output logic [7:0]  checksum
);

  logic [7:0]  first_q, first_d;
  logic [15:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic [7:0]  chk_q, chk_d;

  // Next-state for byte pairing and checksum.
  always_comb begin
    first_d      = first_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    chk_d        = chk_q;
    if (take_first) begin
      first_d = byte_data;
    end else begin
      first_d = first_q;
    end
    if (take_second) begin
      word_d       = pack_word(first_q, byte_data);
      word_valid_d = 1'b1;
    end else begin
      word_d       = word_q;
      word_valid_d = 1'b0;
    end
    if (clr) begin
      chk_d = 8'h00;
    end else if (xor_en) begin
      chk_d = chk_q ^ byte_data;
    end else begin
      chk_d = chk_q;
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q      <= 8'h00;
      word_q       <= 16'h0000;
      word_valid_q <= 1'b0;
      chk_q        <= 8'h00;
    end else begin
      first_q      <= first_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      chk_q        <= chk_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word       = word_q;
  assign checksum   = chk_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked byte frame, writes the
// words into instruction memory and holds the CPU in reset until verified.
module imem_boot_loader
  import cpu_pkg::*;
#(
  parameter logic [15:0] MAX_WORDS = 16'd256,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] ADDR_STEP = 16'd4,
  parameter logic [15:0] TIMEOUT   = 16'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] words_loaded
);

  boot_state_e state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [15:0] words_q, words_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] tmo_q, tmo_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        hold_q, hold_d;

  logic        ready_s, accept_s, start_s;
  logic [15:0] len_s, words_next_s;
  logic [7:0]  chk_s;
  logic [15:0] word_s;
  logic        word_valid_s;

  assign ready_s = (state_q == ST_LEN_HI)  || (state_q == ST_LEN_LO) ||
                   (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                   (state_q == ST_CHECK);
  assign accept_s     = in_valid & ready_s;
  assign start_s      = start & ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                 (state_q == ST_ERROR));
  assign len_s        = {len_hi_q, in_data};
  assign words_next_s = words_q + 16'd1;

  boot_byte_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clr         (start_s),
    .take_first  (accept_s && (state_q == ST_DATA_HI)),
    .take_second (accept_s && (state_q == ST_DATA_LO)),
    .xor_en      (accept_s && (state_q != ST_CHECK)),
    .byte_data   (in_data),
    .word_valid  (word_valid_s),
    .word        (word_s),
    .checksum    (chk_s)
  );

  // Frame FSM, address generation and idle timeout.
  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    words_d    = words_q;
    addr_d     = addr_q;
    tmo_d      = tmo_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    hold_d     = hold_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_s) begin
          state_d    = ST_LEN_HI;
          words_d    = 16'd0;
          tmo_d      = 16'd0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          hold_d     = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          len_hi_d = in_data;
          state_d  = ST_LEN_LO;
        end else begin
          len_hi_d = len_hi_q;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          len_d = len_s;
          if ((len_s == 16'd0) || (len_s > MAX_WORDS)) begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
          end else begin
            state_d = ST_DATA_HI;
          end
        end else begin
          len_d = len_q;
        end
      end
      ST_DATA_HI: begin
        if (accept_s) begin
          state_d = ST_DATA_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA_LO: begin
        if (accept_s) begin
          // Address of this word uses the pre-increment count.
          addr_d  = BASE_ADDR + (words_q * ADDR_STEP);
          words_d = words_next_s;
          if (words_next_s == len_q) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA_HI;
          end
        end else begin
          words_d = words_q;
        end
      end
      ST_CHECK: begin
        if (accept_s) begin
          if (in_data == chk_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An accepted byte always beats the timeout in the same cycle.
    if (ready_s) begin
      if (accept_s) begin
        tmo_d = 16'd0;
      end else if (tmo_q == (TIMEOUT - 16'd1)) begin
        tmo_d      = 16'd0;
        state_d    = ST_ERROR;
        err_d      = 1'b1;
        err_code_d = ERR_TMO;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end else begin
      tmo_d = tmo_d;
    end
  end

  // Loader state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_hi_q   <= 8'h00;
      len_q      <= 16'd0;
      words_q    <= 16'd0;
      addr_q     <= BASE_ADDR;
      tmo_q      <= 16'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      hold_q     <= hold_d;
    end
  end

  assign in_ready     = ready_s;
  assign imem_we      = word_valid_s;
  assign imem_wdata   = word_s;
  assign imem_addr    = addr_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: nominal, checksum, length, timeout,
// back-pressure, start priority and asynchronous reset cases.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  int total = 0;
  int bad = 0;
  bit bp = 1'b0;
  logic [15:0] wa[$];
  logic [15:0] wd[$];

  imem_boot_loader #(.TIMEOUT(16'd16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err), .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write-strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    if (bp) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("handshake", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] chk_byte);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(chk_byte);
  endtask

  task automatic expect_nominal_writes(input string tag);
    chk({tag, "_nwr"}, wa.size(), 32'd2);
    if (wa.size() >= 2) begin
      chk({tag, "_a0"}, {16'd0, wa[0]}, 32'h0000);
      chk({tag, "_d0"}, {16'd0, wd[0]}, 32'h1234);
      chk({tag, "_a1"}, {16'd0, wa[1]}, 32'h0004);
      chk({tag, "_d1"}, {16'd0, wd[1]}, 32'hABCD);
    end else begin
      chk({tag, "_writes_missing"}, wa.size(), 32'd2);
    end
  endtask

  task automatic expect_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, imem_we},  32'd0);
    chk({tag, "_addr"},  {16'd0, imem_addr}, 32'h0000);
    chk({tag, "_wdata"}, {16'd0, imem_wdata}, 32'h0000);
    chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_err"},   {31'd0, err}, 32'd0);
    chk({tag, "_code"},  {30'd0, err_code}, 32'd0);
    chk({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    expect_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);

    // Start together with a valid byte in IDLE: byte must stay pending.
    start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    chk("prio_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h42);
    expect_nominal_writes("nom");
    chk("nom_done",  {31'd0, done}, 32'd1);
    chk("nom_hold",  {31'd0, cpu_hold}, 32'd0);
    chk("nom_err",   {31'd0, err}, 32'd0);
    chk("nom_words", {16'd0, words_loaded}, 32'd2);

    // Bad checksum.
    wa.delete(); wd.delete();
    pulse_start();
    chk("restart_done", {31'd0, done}, 32'd0);
    send_frame(8'h43);
    expect_nominal_writes("chk");
    chk("chk_err",  {31'd0, err}, 32'd1);
    chk("chk_code", {30'd0, err_code}, 32'd2);
    chk("chk_hold", {31'd0, cpu_hold}, 32'd1);
    chk("chk_done", {31'd0, done}, 32'd0);

    // Bad lengths.
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    chk("len0_err",  {31'd0, err}, 32'd1);
    chk("len0_code", {30'd0, err_code}, 32'd1);
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    chk("len257_err",  {31'd0, err}, 32'd1);
    chk("len257_code", {30'd0, err_code}, 32'd1);
    repeat (2) @(negedge clk);
    chk("len_nwr", wa.size(), 32'd0);

    // Timeout after exactly 16 idle cycles.
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    repeat (15) @(negedge clk);
    chk("tmo_early_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("tmo_err",  {31'd0, err}, 32'd1);
    chk("tmo_code", {30'd0, err_code}, 32'd3);
    chk("tmo_hold", {31'd0, cpu_hold}, 32'd1);

    // Random back-pressure on the nominal frame.
    wa.delete(); wd.delete();
    bp = 1'b1;
    pulse_start();
    send_frame(8'h42);
    bp = 1'b0;
    expect_nominal_writes("bp");
    chk("bp_done", {31'd0, done}, 32'd1);

    // Start during DATA_HI is ignored; frame 00 01 12 34, CHK 0x27.
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    pulse_start();
    chk("ign_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h27);
    chk("ign_done",  {31'd0, done}, 32'd1);
    chk("ign_words", {16'd0, words_loaded}, 32'd1);
    chk("ign_nwr",   wa.size(), 32'd1);
    if (wa.size() >= 1) begin
      chk("ign_d0", {16'd0, wd[0]}, 32'h1234);
    end else begin
      chk("ign_write_missing", wa.size(), 32'd1);
    end

    // Asynchronous reset while the first write strobe is high.
    pulse_start();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    chk("pre_rst_we", {31'd0, imem_we}, 32'd1);
    #1 rst = 1'b0;
    #1 expect_reset_outputs("arst");
    repeat (2) @(negedge clk);
    chk("arst_hold_we", {31'd0, imem_we}, 32'd0);
    rst = 1'b1;
    wa.delete(); wd.delete();
    @(negedge clk);
    pulse_start();
    send_frame(8'h42);
    expect_nominal_writes("post");
    chk("post_done", {31'd0, done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
